// File: rtl/mem_issue_queue_pkg.sv
// rtl/mem_issue_queue_pkg.sv - shared instruction, control and queue-entry types for the memory issue queue
package rv32i_types;

    // Tags are stored zero-extended so entry structs stay fixed while TAG_W remains a module parameter.
    localparam int TAG_W_MAX = 8;

    typedef enum logic [1:0] {
        mm_none = 2'd0,
        ld      = 2'd1,
        st      = 2'd2
    } mm_op_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
    } ooo_instr_t;

    typedef struct packed {
        mm_op_t     mm_op_sel;
        logic [2:0] funct3;
    } ctrl_word_t;

    typedef struct packed {
        ooo_instr_t           instr;
        ctrl_word_t           ctrl;
        logic [TAG_W_MAX-1:0] rob_id;
        logic [TAG_W_MAX-1:0] rs1_tag;
        logic [TAG_W_MAX-1:0] rs2_tag;
        logic                 rs1_ready;
        logic                 rs2_ready;
        logic                 valid;
    } mem_q_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SQUASH = 2'd2
    } mem_q_state_t;

    // Stores may only touch memory once they are the oldest instruction in the ROB.
    function automatic logic can_issue(mem_q_entry_t e, logic [TAG_W_MAX-1:0] head_id);
        if (e.ctrl.mm_op_sel == st) begin
            return e.rs1_ready && e.rs2_ready && (e.rob_id == head_id);
        end
        return e.rs1_ready;
    endfunction

endpackage

// File: rtl/mem_issue_queue_wakeup.sv
// rtl/mem_issue_queue_wakeup.sv - one operand slot: CDB tag compare and data capture
module mem_q_wakeup
    import rv32i_types::*;
(
    input  logic                 valid,
    input  logic                 ready_in,
    input  logic [TAG_W_MAX-1:0] tag,
    input  logic [31:0]          data_in,
    input  logic                 cdb_valid,
    input  logic [TAG_W_MAX-1:0] cdb_tag,
    input  logic [31:0]          cdb_data,
    output logic                 ready_out,
    output logic [31:0]          data_out
);
    logic hit;

    assign hit       = valid && !ready_in && cdb_valid && (tag == cdb_tag);
    assign ready_out = ready_in || hit;
    assign data_out  = hit ? cdb_data : data_in;

endmodule

// File: rtl/mem_issue_queue.sv
// rtl/mem_issue_queue.sv - in-order load/store issue queue feeding mem_fu with CDB wakeup
// Optional MEM_Q_PERF_EN adds saturating load/store/stall counters.
module mem_issue_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dispatch_valid,
    input  ooo_instr_t       dispatch_instr,
    input  ctrl_word_t       dispatch_ctrl_word,
    input  logic [TAG_W-1:0] dispatch_rob_id,
    input  logic [TAG_W-1:0] dispatch_rs1_tag,
    input  logic [TAG_W-1:0] dispatch_rs2_tag,
    input  logic             dispatch_rs1_ready,
    input  logic             dispatch_rs2_ready,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic [TAG_W-1:0] rob_head_id,
    input  logic             flush,
    input  logic             dmem_resp,
    output ooo_instr_t       mem_issue_instr,
    output ctrl_word_t       mem_issue_ctrl_word,
    output logic             mem_result_squash,
    output logic             mem_q_full
`ifdef MEM_Q_PERF_EN
   ,output logic [31:0]      perf_loads,
    output logic [31:0]      perf_stores,
    output logic [31:0]      perf_stall_cycles
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    mem_q_entry_t entries_q [DEPTH];
    mem_q_entry_t entries_d [DEPTH];
    mem_q_entry_t src       [DEPTH];
    mem_q_entry_t woken     [DEPTH];
    logic         rs1_rdy_w [DEPTH];
    logic         rs2_rdy_w [DEPTH];
    logic [31:0]  rs1_dat_w [DEPTH];
    logic [31:0]  rs2_dat_w [DEPTH];

    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    mem_q_state_t         state_q, state_d;
    ooo_instr_t           issue_instr_q, issue_instr_d;
    ctrl_word_t           issue_ctrl_q, issue_ctrl_d;
    logic [IDX_W-1:0]     head_idx, next_idx, tail_idx;
    logic [TAG_W_MAX-1:0] cdb_tag_x, head_id_x;
    mem_q_entry_t         disp_entry, head_e, next_e;
    logic                 enq, pop, keep_store;

    assign head_idx  = head_q[IDX_W-1:0];
    assign next_idx  = head_idx + IDX_W'(1);
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign cdb_tag_x = TAG_W_MAX'(cdb_tag);
    assign head_id_x = TAG_W_MAX'(rob_head_id);

    assign mem_q_full          = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign mem_result_squash   = (state_q == SQUASH) && dmem_resp;
    assign mem_issue_instr     = issue_instr_q;
    assign mem_issue_ctrl_word = issue_ctrl_q;

    // A slot popped while full may be refilled in the same cycle.
    assign pop = (state_q == ISSUE) && dmem_resp;
    assign enq = dispatch_valid && !flush && (!mem_q_full || pop);

    always_comb begin
        disp_entry           = '0;
        disp_entry.instr     = dispatch_instr;
        disp_entry.ctrl      = dispatch_ctrl_word;
        disp_entry.rob_id    = TAG_W_MAX'(dispatch_rob_id);
        disp_entry.rs1_tag   = TAG_W_MAX'(dispatch_rs1_tag);
        disp_entry.rs2_tag   = TAG_W_MAX'(dispatch_rs2_tag);
        disp_entry.rs1_ready = dispatch_rs1_ready;
        disp_entry.rs2_ready = dispatch_rs2_ready;
        disp_entry.valid     = 1'b1;
    end

    // The incoming entry passes through the same wakeup as stored ones, so a same-cycle broadcast is caught.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            src[i] = (enq && (tail_idx == IDX_W'(i))) ? disp_entry : entries_q[i];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        mem_q_wakeup u_rs1 (
            .valid(src[g].valid), .ready_in(src[g].rs1_ready), .tag(src[g].rs1_tag),
            .data_in(src[g].instr.rs1_data), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag_x),
            .cdb_data(cdb_data), .ready_out(rs1_rdy_w[g]), .data_out(rs1_dat_w[g])
        );
        mem_q_wakeup u_rs2 (
            .valid(src[g].valid), .ready_in(src[g].rs2_ready), .tag(src[g].rs2_tag),
            .data_in(src[g].instr.rs2_data), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag_x),
            .cdb_data(cdb_data), .ready_out(rs2_rdy_w[g]), .data_out(rs2_dat_w[g])
        );
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i]                = src[i];
            woken[i].rs1_ready      = rs1_rdy_w[i];
            woken[i].rs2_ready      = rs2_rdy_w[i];
            woken[i].instr.rs1_data = rs1_dat_w[i];
            woken[i].instr.rs2_data = rs2_dat_w[i];
        end
    end

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        issue_instr_d = issue_instr_q;
        issue_ctrl_d  = issue_ctrl_q;
        keep_store    = 1'b0;
        head_e        = woken[head_idx];
        next_e        = woken[next_idx];
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = woken[i];
        end

        if (pop) begin
            head_d = head_q + PTR_W'(1);
            if (!(enq && (tail_idx == head_idx))) begin
                entries_d[head_idx].valid = 1'b0;
            end
        end
        if (enq) begin
            tail_d = tail_q + PTR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!flush && entries_q[head_idx].valid && can_issue(head_e, head_id_x)) begin
                    issue_instr_d       = head_e.instr;
                    issue_instr_d.valid = 1'b1;
                    issue_ctrl_d        = head_e.ctrl;
                    state_d             = ISSUE;
                end
            end
            ISSUE: begin
                if (dmem_resp) begin
                    if (!flush && entries_q[next_idx].valid && can_issue(next_e, head_id_x)) begin
                        issue_instr_d       = next_e.instr;
                        issue_instr_d.valid = 1'b1;
                        issue_ctrl_d        = next_e.ctrl;
                    end else begin
                        issue_instr_d = '0;
                        issue_ctrl_d  = '0;
                        state_d       = IDLE;
                    end
                end else if (flush) begin
                    // A load already sent to memory cannot be recalled; a store is committing and survives.
                    if (issue_ctrl_q.mm_op_sel == st) begin
                        keep_store = 1'b1;
                    end else begin
                        state_d = SQUASH;
                    end
                end
            end
            SQUASH: begin
                if (dmem_resp) begin
                    issue_instr_d = '0;
                    issue_ctrl_d  = '0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            if (keep_store) begin
                entries_d[head_idx].valid = 1'b1;
                tail_d                    = head_q + PTR_W'(1);
            end else begin
                tail_d = head_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            issue_instr_q <= '0;
            issue_ctrl_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            issue_instr_q <= issue_instr_d;
            issue_ctrl_q  <= issue_ctrl_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

`ifdef MEM_Q_PERF_EN
    logic [31:0] perf_loads_q, perf_loads_d;
    logic [31:0] perf_stores_q, perf_stores_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_loads_d  = perf_loads_q;
        perf_stores_d = perf_stores_q;
        perf_stall_d  = perf_stall_q;
        if (pop && (issue_ctrl_q.mm_op_sel == ld) && (perf_loads_q != '1)) begin
            perf_loads_d = perf_loads_q + 32'd1;
        end
        if (pop && (issue_ctrl_q.mm_op_sel == st) && (perf_stores_q != '1)) begin
            perf_stores_d = perf_stores_q + 32'd1;
        end
        if ((state_q == IDLE) && entries_q[head_idx].valid && !can_issue(head_e, head_id_x)
            && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_loads_q  <= perf_loads_d;
            perf_stores_q <= perf_stores_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_loads        = perf_loads_q;
    assign perf_stores       = perf_stores_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
